// File: rtl/motor_drive_array_if.sv
// Control and status bundle between the speed loop and motor_drive_array.
// The speed loop (or bench) takes the master side, the drive core the slave side.
interface motor_drive_array_if #(
  parameter int N_CH    = 2,
  parameter int PWM_W   = 16,
  parameter int PRESC_W = 8,
  parameter int TACH_W  = 26
);
  logic                     enable_in;
  logic [PRESC_W-1:0]       prescale_in;
  logic [PWM_W-1:0]         period_in;
  logic [N_CH*PWM_W-1:0]    duty_in;
  logic [N_CH-1:0]          duty_valid_in;
  logic [N_CH-1:0]          tach_pulse_in;
  logic                     motor_en_out;
  logic [N_CH-1:0]          pwm_out;
  logic                     period_start_out;
  logic [N_CH*TACH_W-1:0]   tach_period_out;
  logic [N_CH-1:0]          tach_valid_out;
  logic [N_CH-1:0]          tach_stall_out;

  modport master (
    output enable_in, prescale_in, period_in, duty_in, duty_valid_in, tach_pulse_in,
    input  motor_en_out, pwm_out, period_start_out, tach_period_out, tach_valid_out,
           tach_stall_out
  );

  modport slave (
    input  enable_in, prescale_in, period_in, duty_in, duty_valid_in, tach_pulse_in,
    output motor_en_out, pwm_out, period_start_out, tach_period_out, tach_valid_out,
           tach_stall_out
  );
endinterface

// File: rtl/motor_drive_array.sv
// N-channel motor drive core: double-buffered PWM plus tachometer period/stall measurement.
// Optional MOTOR_PWM_RAMP_EN slew-limits the active duty by RAMP_STEP per PWM period.
module motor_drive_array #(
  parameter int N_CH      = 2,
  parameter int PWM_W     = 16,
  parameter int PRESC_W   = 8,
  parameter int TACH_W    = 26,
  parameter int STALL_CYC = 5_000_000,
  parameter int RAMP_STEP = 256
) (
  input logic                clk,
  input logic                reset_n,
  motor_drive_array_if.slave bus
);

  typedef enum logic [1:0] {TACH_ARM, TACH_MEAS, TACH_STALL} tach_state_e;

  localparam logic [TACH_W-1:0] TACH_MAX  = '1;
  localparam logic [TACH_W-1:0] STALL_LIM = TACH_W'(STALL_CYC);

  if (RAMP_STEP < 1 || RAMP_STEP >= (1 << PWM_W)) begin : g_bad_ramp_step
    $error("motor_drive_array: RAMP_STEP must lie in 1 .. 2**PWM_W-1");
  end

  // Two-flop synchronizers and registered edge detect for the asynchronous inputs
  logic              en_s1_q, en_s2_q;
  logic [N_CH-1:0]   tach_s1_q, tach_s2_q, tach_prev_q, tach_edge_q;

  // PWM timebase
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PWM_W-1:0]   cnt_q, cnt_d;
  logic               tick, boundary;
  logic               ps_q;

  // Per-channel duty buffering and PWM output
  logic [PWM_W-1:0]   pend_q [N_CH];
  logic [PWM_W-1:0]   pend_d [N_CH];
  logic [PWM_W-1:0]   act_q  [N_CH];
  logic [PWM_W-1:0]   act_d  [N_CH];
  logic [N_CH-1:0]    pwm_q, pwm_d;

  // Per-channel tachometer measurement
  logic [TACH_W-1:0]  tcnt_q [N_CH];
  logic [TACH_W-1:0]  tcnt_d [N_CH];
  logic [TACH_W-1:0]  tper_q [N_CH];
  logic [TACH_W-1:0]  tper_d [N_CH];
  tach_state_e        st_q   [N_CH];
  tach_state_e        st_d   [N_CH];
  logic [N_CH-1:0]    tvalid_q, tvalid_d;
  logic [N_CH-1:0]    tstall_q, tstall_d;
  logic [N_CH*TACH_W-1:0] tach_period_flat;

`ifdef MOTOR_PWM_RAMP_EN
  localparam logic [PWM_W-1:0] RAMP_STEP_W = PWM_W'(RAMP_STEP);

  function automatic logic [PWM_W-1:0] ramp_toward(input logic [PWM_W-1:0] act,
                                                   input logic [PWM_W-1:0] pend);
    logic [PWM_W-1:0] result;
    if (pend > act) result = (pend - act > RAMP_STEP_W) ? act + RAMP_STEP_W : pend;
    else            result = (act - pend > RAMP_STEP_W) ? act - RAMP_STEP_W : pend;
    return result;
  endfunction
`endif

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    // >= rather than == keeps the timebase sane when prescale_in/period_in shrink mid-count
    tick     = (presc_q >= bus.prescale_in);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    boundary = tick && (cnt_q >= bus.period_in);
    cnt_d    = cnt_q;
    if (tick) cnt_d = boundary ? '0 : cnt_q + 1'b1;

    pwm_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      pend_d[i] = bus.duty_valid_in[i] ? bus.duty_in[i*PWM_W +: PWM_W] : pend_q[i];
`ifdef MOTOR_PWM_RAMP_EN
      act_d[i]  = boundary ? ramp_toward(act_q[i], pend_q[i]) : act_q[i];
`else
      act_d[i]  = boundary ? pend_q[i] : act_q[i];
`endif
      pwm_d[i]  = en_s2_q & (cnt_q < act_q[i]);
    end
  end

  always_comb begin
    tvalid_d = '0;
    tstall_d = tstall_q;
    for (int i = 0; i < N_CH; i++) begin
      tcnt_d[i] = (tcnt_q[i] == TACH_MAX) ? tcnt_q[i] : tcnt_q[i] + 1'b1;
      tper_d[i] = tper_q[i];
      st_d[i]   = st_q[i];
      case (st_q[i])
        TACH_ARM: begin
          if (tach_edge_q[i]) begin
            tcnt_d[i] = TACH_W'(1);
            st_d[i]   = TACH_MEAS;
          end
        end
        TACH_MEAS: begin
          if (tach_edge_q[i]) begin
            tper_d[i]   = tcnt_q[i];
            tvalid_d[i] = 1'b1;
            tcnt_d[i]   = TACH_W'(1);
          end else if (tcnt_q[i] == STALL_LIM) begin
            st_d[i]     = TACH_STALL;
            tstall_d[i] = 1'b1;
          end
        end
        TACH_STALL: begin
          // Restart the measurement without reporting the stalled interval
          if (tach_edge_q[i]) begin
            tstall_d[i] = 1'b0;
            tcnt_d[i]   = TACH_W'(1);
            st_d[i]     = TACH_MEAS;
          end
        end
        default: st_d[i] = TACH_ARM;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the small duty/tach register arrays
  // are plain flops, so they are cleared by the asynchronous reset like every other register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_s1_q     <= 1'b0;
      en_s2_q     <= 1'b0;
      tach_s1_q   <= '0;
      tach_s2_q   <= '0;
      tach_prev_q <= '0;
      tach_edge_q <= '0;
      presc_q     <= '0;
      cnt_q       <= '0;
      ps_q        <= 1'b0;
      pwm_q       <= '0;
      tvalid_q    <= '0;
      tstall_q    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        pend_q[i] <= '0;
        act_q[i]  <= '0;
        tcnt_q[i] <= '0;
        tper_q[i] <= '0;
        st_q[i]   <= TACH_ARM;
      end
    end else begin
      en_s1_q     <= bus.enable_in;
      en_s2_q     <= en_s1_q;
      tach_s1_q   <= bus.tach_pulse_in;
      tach_s2_q   <= tach_s1_q;
      tach_prev_q <= tach_s2_q;
      tach_edge_q <= tach_s2_q & ~tach_prev_q;
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      ps_q        <= boundary;
      pwm_q       <= pwm_d;
      tvalid_q    <= tvalid_d;
      tstall_q    <= tstall_d;
      for (int i = 0; i < N_CH; i++) begin
        pend_q[i] <= pend_d[i];
        act_q[i]  <= act_d[i];
        tcnt_q[i] <= tcnt_d[i];
        tper_q[i] <= tper_d[i];
        st_q[i]   <= st_d[i];
      end
    end
  end

  always_comb begin
    tach_period_flat = '0;
    for (int i = 0; i < N_CH; i++) tach_period_flat[i*TACH_W +: TACH_W] = tper_q[i];
  end

  assign bus.motor_en_out     = en_s2_q;
  assign bus.pwm_out          = pwm_q;
  assign bus.period_start_out = ps_q;
  assign bus.tach_period_out  = tach_period_flat;
  assign bus.tach_valid_out   = tvalid_q;
  assign bus.tach_stall_out   = tstall_q;

endmodule

// File: tb/tb_motor_drive_array.sv
// Self-checking bench for motor_drive_array: table-driven PWM vectors, hand-written
// boundary/enable/ramp/reset sequences, and a queue scoreboard for tachometer periods.
module tb_motor_drive_array;

  localparam int N_CH    = 2;
  localparam int PWM_W   = 16;
  localparam int PRESC_W = 8;
  localparam int TACH_W  = 26;

  logic   clk = 1'b0;
  logic   reset_n = 1'b0;
  longint cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  motor_drive_array_if #(.N_CH(N_CH), .PWM_W(PWM_W), .PRESC_W(PRESC_W), .TACH_W(TACH_W)) bus ();

  motor_drive_array #(
    .N_CH(N_CH), .PWM_W(PWM_W), .PRESC_W(PRESC_W), .TACH_W(TACH_W),
    .STALL_CYC(2000), .RAMP_STEP(256)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- tach scoreboard ----------------
  typedef struct {
    int     ch;
    int     period;
    longint cyc;
  } tach_exp_t;

  tach_exp_t exp_q[$];
  longint    last_valid_cyc [N_CH];

  always @(negedge clk) begin
    if (reset_n) begin
      for (int c = 0; c < N_CH; c++) begin
        if (bus.tach_valid_out[c]) begin
          int idx;
          idx = -1;
          last_valid_cyc[c] = cyc;
          for (int k = 0; k < exp_q.size(); k++) begin
            if (idx < 0 && exp_q[k].ch == c) idx = k;
          end
          if (idx < 0) begin
            check($sformatf("tach%0d_unexpected_valid", c), 1, 0);
          end else begin
            check($sformatf("tach%0d_period", c), bus.tach_period_out[c*TACH_W +: TACH_W],
                  exp_q[idx].period);
            check($sformatf("tach%0d_latency", c), cyc - exp_q[idx].cyc, 4);
            exp_q.delete(idx);
          end
        end
      end
    end
  end

  task automatic tach_train(input int ch, input int n_edges, input int spacing,
                            input bit first_counts);
    for (int e = 0; e < n_edges; e++) begin
      tach_exp_t x;
      @(negedge clk);
      bus.tach_pulse_in[ch] = 1'b1;
      if (first_counts || e > 0) begin
        x.ch = ch;
        x.period = spacing;
        x.cyc = cyc;
        exp_q.push_back(x);
      end
      repeat (20) @(negedge clk);
      bus.tach_pulse_in[ch] = 1'b0;
      repeat (spacing - 21) @(negedge clk);
    end
  endtask

  // ---------------- PWM helpers ----------------
  task automatic wait_ps(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      seen = bus.period_start_out;
    end
    if (!seen) check({name, "_ps_timeout"}, 0, 1);
  endtask

  task automatic measure(input int window, output int hi0, output int hi1, output int ps_pos);
    hi0 = 0;
    hi1 = 0;
    ps_pos = -1;
    for (int i = 1; i <= window; i++) begin
      @(negedge clk);
      hi0 += int'(bus.pwm_out[0]);
      hi1 += int'(bus.pwm_out[1]);
      if (bus.period_start_out && ps_pos < 0) ps_pos = i;
    end
  endtask

  task automatic load_duty(input logic [PWM_W-1:0] d0, input logic [PWM_W-1:0] d1,
                           input logic [N_CH-1:0] mask);
    bus.duty_in = {d1, d0};
    bus.duty_valid_in = mask;
    @(negedge clk);
    bus.duty_valid_in = '0;
  endtask

  typedef struct {
    logic [PRESC_W-1:0] presc;
    logic [PWM_W-1:0]   period;
    logic [PWM_W-1:0]   d0;
    logic [PWM_W-1:0]   d1;
    int                 window;
    int                 hi0;
    int                 hi1;
    string              name;
  } vec_t;

  vec_t   vecs [5];
  int     hi0, hi1, ps_pos;
  int     ramp_exp [4];
  longint ps_ref, stall_cyc;
  bit     seen;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'd0, 16'd9,  16'd3,  16'd7,  10,  3,  7,  "p9_d3_d7"};
    vecs[1] = '{8'd0, 16'd9,  16'd0,  16'd10, 10,  0,  10, "p9_zero_over"};
    vecs[2] = '{8'd1, 16'd4,  16'd2,  16'd5,  10,  4,  10, "presc1_p4"};
    vecs[3] = '{8'd2, 16'd7,  16'd8,  16'd1,  24,  24, 3,  "presc2_p7"};
    vecs[4] = '{8'd0, 16'd99, 16'd50, 16'd99, 100, 50, 99, "p99"};
`ifdef MOTOR_PWM_RAMP_EN
    ramp_exp = '{256, 512, 768, 1000};
`else
    ramp_exp = '{1000, 1000, 1000, 1000};
`endif

    bus.enable_in     = 1'b1;
    bus.prescale_in   = '0;
    bus.period_in     = 16'd9;
    bus.duty_in       = '0;
    bus.duty_valid_in = '0;
    bus.tach_pulse_in = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_motor_en", bus.motor_en_out, 0);
    check("rst_pwm", bus.pwm_out, 0);
    check("rst_period_start", bus.period_start_out, 0);
    check("rst_tach_valid", bus.tach_valid_out, 0);
    check("rst_tach_stall", bus.tach_stall_out, 0);
    check("rst_tach_period", bus.tach_period_out, 0);

    reset_n = 1'b1;
    @(negedge clk);
    check("en_sync_1clk", bus.motor_en_out, 0);
    @(negedge clk);
    check("en_sync_2clk", bus.motor_en_out, 1);

    // Table-driven steady-state PWM vectors
    for (int v = 0; v < 5; v++) begin
      bus.prescale_in = vecs[v].presc;
      bus.period_in   = vecs[v].period;
      load_duty(vecs[v].d0, vecs[v].d1, 2'b11);
      repeat (3) wait_ps(vecs[v].name);
      measure(vecs[v].window, hi0, hi1, ps_pos);
      check({vecs[v].name, "_hi0"}, hi0, vecs[v].hi0);
      check({vecs[v].name, "_hi1"}, hi1, vecs[v].hi1);
      check({vecs[v].name, "_ps_spacing"}, ps_pos, vecs[v].window);
    end

    // duty_valid on the boundary clk: old pending goes active, new value one period later
    bus.prescale_in = '0;
    bus.period_in   = 16'd9;
    load_duty(16'd3, 16'd0, 2'b11);
    repeat (3) wait_ps("bnd_setup");
    load_duty(16'd5, 16'd0, 2'b01);
    repeat (8) @(negedge clk);
    load_duty(16'd7, 16'd0, 2'b01);
    check("bnd_ps_on_wrap", bus.period_start_out, 1);
    measure(10, hi0, hi1, ps_pos);
    check("bnd_first_period_old_pending", hi0, 5);
    measure(10, hi0, hi1, ps_pos);
    check("bnd_second_period_new", hi0, 7);
    check("bnd_ps_spacing", ps_pos, 10);

    // Enable drop mid-period and re-enable in phase
    ps_ref = cyc;
    repeat (4) @(negedge clk);
    bus.enable_in = 1'b0;
    repeat (3) @(negedge clk);
    check("dis_motor_en", bus.motor_en_out, 0);
    check("dis_pwm", bus.pwm_out, 0);
    measure(20, hi0, hi1, ps_pos);
    check("dis_pwm_stays_low", hi0 + hi1, 0);
    check("dis_counter_runs", (ps_pos > 0) ? 1 : 0, 1);
    bus.enable_in = 1'b1;
    repeat (2) wait_ps("reen");
    check("reen_phase", (cyc - ps_ref) % 10, 0);
    measure(10, hi0, hi1, ps_pos);
    check("reen_hi0", hi0, 7);
    check("reen_ps_spacing", ps_pos, 10);

    // Duty 0 -> 1000 with a 2000-clk period
    bus.period_in = 16'd1999;
    load_duty(16'd0, 16'd0, 2'b11);
    repeat (2) wait_ps("ramp_setup");
    load_duty(16'd1000, 16'd0, 2'b01);
    wait_ps("ramp_start");
    for (int k = 0; k < 4; k++) begin
      measure(2000, hi0, hi1, ps_pos);
      check($sformatf("ramp_period%0d", k), hi0, ramp_exp[k]);
      check($sformatf("ramp_ps_spacing%0d", k), ps_pos, 2000);
    end

    // Tach: first edge arms, then valid every interval on both channels
    fork
      tach_train(0, 5, 1000, 1'b0);
      tach_train(1, 6, 700, 1'b0);
    join
    check("tach_sb_drained", exp_q.size(), 0);
    check("tach0_no_stall_running", bus.tach_stall_out[0], 0);

    // Stall exactly 2000 clk after the last measured edge
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      seen = bus.tach_stall_out[0];
    end
    stall_cyc = cyc;
    check("stall_seen", seen, 1);
    check("stall_delay", stall_cyc - last_valid_cyc[0], 2000);
    check("stall_period_holds", bus.tach_period_out[0 +: TACH_W], 1000);
    tach_train(0, 1, 1000, 1'b0);
    check("stall_cleared", bus.tach_stall_out[0], 0);
    tach_train(0, 1, 1000, 1'b1);
    check("post_stall_sb_drained", exp_q.size(), 0);

    // Asynchronous reset while PWM is high
    bus.period_in = 16'd9;
    load_duty(16'd3, 16'd3, 2'b11);
    repeat (2) wait_ps("rst_mid_setup");
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.pwm_out[0];
    end
    check("rst_mid_pwm_was_high", seen, 1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_pwm", bus.pwm_out, 0);
    check("rst_mid_motor_en", bus.motor_en_out, 0);
    check("rst_mid_tach_period", bus.tach_period_out, 0);
    check("rst_mid_tach_stall", bus.tach_stall_out, 0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
